// File: rtl/float32_arith_unit.sv
// IEEE-754 single-precision add/sub and multiply behind a load/busy handshake,
// plus an independent, fully pipelined float -> signed int32 converter.
module float32_arith_unit #(
  parameter int ADD_LATENCY = 4,
  parameter int MUL_LATENCY = 4,
  parameter int CVT_LATENCY = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] left_arg,
  input  logic [31:0] right_arg,
  input  logic [1:0]  op,
  input  logic        load_args,
  output logic        busy,
  output logic [31:0] result,
  output logic [2:0]  status,
  input  logic [31:0] cvt_in,
  output logic [31:0] cvt_out
);

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam int MAX_LAT = (ADD_LATENCY > MUL_LATENCY) ? ADD_LATENCY : MUL_LATENCY;
  localparam int CNT_W = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE, EXEC} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        result_q, result_d;
  logic [2:0]         status_q, status_d;
  logic [31:0]        a_q, b_q;
  logic [1:0]         op_q;
  logic               load_en;
  logic [34:0]        op_res;
  logic [31:0]        cvt_q [CVT_LATENCY];

  function automatic logic rne_inc(input logic lsb, input logic g, input logic r, input logic s);
    return g & (r | s | lsb);
  endfunction

  // Packs {status, float}; out-of-range exponents saturate to inf or flush to zero.
  function automatic logic [34:0] fp_pack(input logic sign, input logic signed [9:0] e,
                                          input logic [22:0] m);
    if (e >= 10'sd255)   return {3'b001, sign, 8'hFF, 23'd0};
    else if (e <= 10'sd0) return {3'b010, sign, 31'd0};
    else                 return {3'b000, sign, e[7:0], m};
  endfunction

  function automatic logic [34:0] fp_add(input logic [31:0] a, input logic [31:0] b,
                                         input logic sub);
    logic              sa, sb, sx, sy;
    logic [7:0]        ea, eb, ex, ey, d;
    logic [22:0]       ma, mb, mx, my;
    logic [26:0]       xx, yy, ysh, nrm;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic              found, rup;
    logic signed [9:0] exp_r;
    logic [24:0]       rnd;
    logic [34:0]       res;
    sa = a[31];      ea = a[30:23]; ma = a[22:0];
    sb = b[31] ^ sub; eb = b[30:23]; mb = b[22:0];
    res = '0;
    if ((ea == 8'hFF && ma != 23'd0) || (eb == 8'hFF && mb != 23'd0))
      res = {3'b100, QNAN};
    else if (ea == 8'hFF && eb == 8'hFF)
      res = (sa != sb) ? {3'b100, QNAN} : {3'b000, sa, 8'hFF, 23'd0};
    else if (ea == 8'hFF) res = {3'b000, sa, 8'hFF, 23'd0};
    else if (eb == 8'hFF) res = {3'b000, sb, 8'hFF, 23'd0};
    else if (ea == 8'd0 && eb == 8'd0) res = {3'b000, sa & sb, 31'd0};
    else if (ea == 8'd0) res = {3'b000, sb, eb, mb};
    else if (eb == 8'd0) res = {3'b000, sa, ea, ma};
    else begin
      if ({ea, ma} >= {eb, mb}) begin
        sx = sa; ex = ea; mx = ma; sy = sb; ey = eb; my = mb;
      end else begin
        sx = sb; ex = eb; mx = mb; sy = sa; ey = ea; my = ma;
      end
      d  = ex - ey;
      xx = {1'b1, mx, 3'b000};
      yy = {1'b1, my, 3'b000};
      // Bits shifted past the round bit collapse into the sticky LSB.
      if (d > 8'd26) ysh = 27'd1;
      else ysh = (yy >> d) | {26'd0, |(yy & ((27'd1 << d) - 27'd1))};
      if (sx == sy) sum = {1'b0, xx} + {1'b0, ysh};
      else          sum = {1'b0, xx} - {1'b0, ysh};
      if (sum == 28'd0) res = '0;
      else begin
        exp_r = signed'({2'b00, ex});
        nrm   = '0;
        if (sum[27]) begin
          nrm   = sum[27:1] | {26'd0, sum[0]};
          exp_r = exp_r + 10'sd1;
        end else begin
          lz = 5'd0; found = 1'b0;
          for (int i = 26; i >= 0; i--)
            if (!found) begin
              if (sum[i]) found = 1'b1;
              else        lz = lz + 5'd1;
            end
          nrm   = sum[26:0] << lz;
          exp_r = exp_r - signed'({5'd0, lz});
        end
        rup = rne_inc(nrm[3], nrm[2], nrm[1], nrm[0]);
        rnd = {1'b0, nrm[26:3]} + {24'd0, rup};
        if (rnd[24]) begin
          rnd   = rnd >> 1;
          exp_r = exp_r + 10'sd1;
        end
        res = fp_pack(sx, exp_r, rnd[22:0]);
      end
    end
    return res;
  endfunction

  function automatic logic [34:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s, g, st, rup;
    logic [7:0]        ea, eb;
    logic [22:0]       ma, mb;
    logic [47:0]       p;
    logic [23:0]       mant;
    logic [24:0]       rnd;
    logic signed [9:0] exp_r;
    logic              a_inf, b_inf, a_zero, b_zero;
    logic [34:0]       res;
    s  = a[31] ^ b[31];
    ea = a[30:23]; ma = a[22:0];
    eb = b[30:23]; mb = b[22:0];
    a_inf  = (ea == 8'hFF) && (ma == 23'd0);
    b_inf  = (eb == 8'hFF) && (mb == 23'd0);
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    res = '0;
    if ((ea == 8'hFF && ma != 23'd0) || (eb == 8'hFF && mb != 23'd0) ||
        (a_inf && b_zero) || (b_inf && a_zero))
      res = {3'b100, QNAN};
    else if (a_inf || b_inf) res = {3'b000, s, 8'hFF, 23'd0};
    else if (a_zero || b_zero) res = {3'b000, s, 31'd0};
    else begin
      p     = {24'd0, 1'b1, ma} * {24'd0, 1'b1, mb};
      exp_r = signed'({2'b00, ea}) + signed'({2'b00, eb}) - 10'sd127;
      if (p[47]) begin
        mant  = p[47:24]; g = p[23]; st = |p[22:0];
        exp_r = exp_r + 10'sd1;
      end else begin
        mant = p[46:23]; g = p[22]; st = |p[21:0];
      end
      rup = rne_inc(mant[0], g, st, 1'b0);
      rnd = {1'b0, mant} + {24'd0, rup};
      if (rnd[24]) begin
        rnd   = rnd >> 1;
        exp_r = exp_r + 10'sd1;
      end
      res = fp_pack(s, exp_r, rnd[22:0]);
    end
    return res;
  endfunction

  // Float -> int32: value*2^24 held in t, so t[23] is the half bit.
  function automatic logic [31:0] fp_to_int(input logic [31:0] f);
    logic        s, rup;
    logic [7:0]  e;
    logic [22:0] m;
    logic [54:0] t;
    logic [31:0] mag, res;
    s = f[31]; e = f[30:23]; m = f[22:0];
    res = '0;
    if (e == 8'hFF && m != 23'd0) res = 32'h80000000;
    else if (e >= 8'd158)         res = s ? 32'h80000000 : 32'h7FFFFFFF;
    else if (e < 8'd126)          res = 32'd0;
    else begin
      t   = {31'd0, 1'b1, m} << (e - 8'd126);
      rup = rne_inc(t[24], t[23], t[22], |t[21:0]);
      mag = {1'b0, t[54:24]} + {31'd0, rup};
      res = s ? (~mag + 32'd1) : mag;
    end
    return res;
  endfunction

  always_comb begin
    op_res = op_q[1] ? fp_mul(a_q, b_q) : fp_add(a_q, b_q, ~op_q[0]);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    status_d = status_q;
    load_en  = 1'b0;
    unique case (state_q)
      IDLE: if (load_args) begin
        load_en = 1'b1;
        state_d = EXEC;
        cnt_d   = op[1] ? CNT_W'(MUL_LATENCY - 1) : CNT_W'(ADD_LATENCY - 1);
      end
      EXEC: if (cnt_q == '0) begin
        state_d              = IDLE;
        {status_d, result_d} = op_res;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_en) begin
      a_q  <= left_arg;
      b_q  <= right_arg;
      op_q <= op;
    end
  end

  // Converter: stage 0 does the conversion, the remaining stages only delay.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < CVT_LATENCY; i++) cvt_q[i] <= '0;
    end else begin
      cvt_q[0] <= fp_to_int(cvt_in);
      for (int i = 1; i < CVT_LATENCY; i++) cvt_q[i] <= cvt_q[i-1];
    end
  end

  assign busy    = (state_q == EXEC);
  assign result  = result_q;
  assign status  = status_q;
  assign cvt_out = cvt_q[CVT_LATENCY-1];

endmodule

// File: tb/tb_float32_arith_unit.sv
// Scoreboard bench for float32_arith_unit: arithmetic ops, handshake, reset abort
// and the converter stream.
module tb_float32_arith_unit;

  localparam int ADD_LAT = 4;
  localparam int MUL_LAT = 4;
  localparam int CVT_LAT = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] left_arg, right_arg, cvt_in;
  logic [1:0]  op;
  logic        load_args;
  logic        busy;
  logic [31:0] result, cvt_out;
  logic [2:0]  status;

  int vectors = 0;
  int miscompares = 0;

  logic [34:0] op_sb[$];
  logic [31:0] cvt_sb[$];

  float32_arith_unit #(
    .ADD_LATENCY(ADD_LAT),
    .MUL_LATENCY(MUL_LAT),
    .CVT_LATENCY(CVT_LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .left_arg(left_arg),
    .right_arg(right_arg),
    .op(op),
    .load_args(load_args),
    .busy(busy),
    .result(result),
    .status(status),
    .cvt_in(cvt_in),
    .cvt_out(cvt_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r,
                        input logic [2:0] exp_s, input bit poke);
    int n;
    int lat;
    logic [34:0] e;
    lat = o[1] ? MUL_LAT : ADD_LAT;
    op_sb.push_back({exp_s, exp_r});
    @(negedge clk);
    load_args = 1'b1; op = o; left_arg = a; right_arg = b;
    @(posedge clk); #1;
    check_eq({tag, "_busy_set"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    load_args = 1'b0; left_arg = $urandom; right_arg = $urandom; op = 2'($urandom);
    n = 0;
    while (busy && n < 64) begin
      n++;
      load_args = (poke && n == 1);
      @(negedge clk);
    end
    load_args = 1'b0;
    check_eq({tag, "_busy_len"}, n, lat);
    e = op_sb.pop_front();
    check_eq({tag, "_result"}, result, e[31:0]);
    check_eq({tag, "_status"}, {29'd0, status}, {29'd0, e[34:32]});
    repeat (3) @(negedge clk);
    check_eq({tag, "_hold"}, result, e[31:0]);
  endtask

  logic [31:0] cvt_vec [12] = '{
    32'h40200000, 32'h40600000, 32'hBFC00000, 32'h4F800000,
    32'h7FC00000, 32'hCF800000, 32'h3F000000, 32'h3F400000,
    32'h00400000, 32'h42C90000, 32'h4EFFFFFF, 32'hCF000000
  };
  logic [31:0] cvt_exp [12] = '{
    32'h00000002, 32'h00000004, 32'hFFFFFFFE, 32'h7FFFFFFF,
    32'h80000000, 32'h80000000, 32'h00000000, 32'h00000001,
    32'h00000000, 32'h00000064, 32'h7FFFFF80, 32'h80000000
  };

  initial begin
    reset = 1'b0; load_args = 1'b0; op = 2'b00;
    left_arg = '0; right_arg = '0; cvt_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_status", {29'd0, status}, 32'd0);
    check_eq("rst_cvt", cvt_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("add_3p2",    2'b01, 32'h40400000, 32'h40000000, 32'h40A00000, 3'b000, 1'b0);
    run_op("sub_1m1",    2'b00, 32'h3F800000, 32'h3F800000, 32'h00000000, 3'b000, 1'b0);
    run_op("sub_5m10",   2'b00, 32'h40A00000, 32'h41200000, 32'hC0A00000, 3'b000, 1'b0);
    run_op("mul_20x6e5", 2'b10, 32'h41A00000, 32'h49127C00, 32'h4B371B00, 3'b000, 1'b0);
    run_op("mul_ovf",    2'b10, 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b001, 1'b0);
    run_op("add_infinf", 2'b01, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b100, 1'b0);
    run_op("mul11_2x3",  2'b11, 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, 1'b0);
    run_op("mul_unf",    2'b10, 32'h00800000, 32'h3F000000, 32'h00000000, 3'b010, 1'b0);
    run_op("add_negz",   2'b01, 32'h80000000, 32'h80000000, 32'h80000000, 3'b000, 1'b0);
    run_op("mul_0xinf",  2'b10, 32'h00000000, 32'h7F800000, 32'h7FC00000, 3'b100, 1'b0);
    run_op("add_tie",    2'b01, 32'h3F800000, 32'h33800000, 32'h3F800000, 3'b000, 1'b0);
    run_op("add_rup",    2'b01, 32'h3F800000, 32'h33C00000, 32'h3F800001, 3'b000, 1'b0);
    run_op("sub_infm1",  2'b00, 32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b000, 1'b0);
    run_op("sub_1minf",  2'b00, 32'h3F800000, 32'h7F800000, 32'hFF800000, 3'b000, 1'b0);
    run_op("mul_neg",    2'b10, 32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000, 1'b0);
    run_op("add_poke",   2'b01, 32'h40400000, 32'h40000000, 32'h40A00000, 3'b000, 1'b1);

    // Reset in the middle of a multiply aborts it and clears the outputs.
    @(negedge clk);
    load_args = 1'b1; op = 2'b10; left_arg = 32'h40000000; right_arg = 32'h40000000;
    @(negedge clk);
    load_args = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_result", result, 32'd0);
    check_eq("abort_status", {29'd0, status}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (MUL_LAT + 2) @(negedge clk);
    check_eq("abort_noresult", result, 32'd0);
    check_eq("abort_idle", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 12 + CVT_LAT; i++) begin
      @(negedge clk);
      if (i >= CVT_LAT) check_eq($sformatf("cvt_%0d", i - CVT_LAT), cvt_out, cvt_sb.pop_front());
      if (i < 12) begin
        cvt_in = cvt_vec[i];
        cvt_sb.push_back(cvt_exp[i]);
      end else begin
        cvt_in = 32'd0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
